// File: rtl/gpio_bcd_display_if.sv
// Bundle of the GPIO value feeding the display converter and the converted
// seven-segment outputs with status flags.
interface gpio_bcd_display_if;
   logic [31:0] din;
   logic [6:0]  hex0;
   logic [6:0]  hex1;
   logic [6:0]  hex2;
   logic [6:0]  hex3;
   logic [6:0]  hex4;
   logic [6:0]  hex5;
   logic [6:0]  hex6;
   logic [6:0]  hex7;
   logic        ovf;
   logic        busy;
   logic        upd;

   modport master (
      output din,
      input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7,
      input  ovf, busy, upd
   );

   modport slave (
      input  din,
      output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7,
      output ovf, busy, upd
   );
endinterface

// File: rtl/gpio_bcd_display.sv
// Binary-to-BCD display driver: double-dabble conversion of a 32-bit GPIO value
// into eight active-low seven-segment digits with leading-zero blanking.
module gpio_bcd_display (
   input  logic                clk,
   input  logic                rst,
   gpio_bcd_display_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] shreg_q, shreg_d;
   logic [31:0] cap_q, cap_d;
   logic [31:0] last_q, last_d;
   logic [39:0] bcd_q, bcd_d;
   logic [39:0] bcd_adj;
   logic [4:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic        upd_q, upd_d;
   logic        busy;
   logic [6:0]  hex_q   [8];
   logic [6:0]  hex_d   [8];
   logic [6:0]  seg_new [8];

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Add-3 correction per digit; digits never exceed 9, so 4 bits suffice.
   generate
      for (genvar gi = 0; gi < 10; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                     bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
      end
   endgenerate

   // A digit is blank only if it and every more-significant digit (incl. 8/9) is zero.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_seg
         if (gi == 0) begin : g_lsd
            assign seg_new[gi] = seg7(bcd_q[3:0]);
         end else begin : g_upper
            assign seg_new[gi] = (bcd_q[39:gi*4] == '0) ? 7'b1111111
                                                        : seg7(bcd_q[gi*4 +: 4]);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.din != last_q) state_d = SHIFT;
         SHIFT:   if (cnt_q == 5'd31) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      shreg_d = shreg_q;
      cap_d   = cap_q;
      last_d  = last_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      upd_d   = 1'b0;
      for (int i = 0; i < 8; i++) hex_d[i] = hex_q[i];
      case (state_q)
         IDLE: begin
            if (bus.din != last_q) begin
               shreg_d = bus.din;
               cap_d   = bus.din;
               bcd_d   = '0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
            cnt_d            = cnt_q + 5'd1;
         end
         DONE: begin
            for (int i = 0; i < 8; i++) hex_d[i] = seg_new[i];
            ovf_d  = (bcd_q[39:32] != 8'd0);
            last_d = cap_q;
            upd_d  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q  <= '0;
         cap_q    <= '0;
         last_q   <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         upd_q    <= 1'b0;
         hex_q[0] <= 7'b1000000;
         for (int i = 1; i < 8; i++) hex_q[i] <= 7'b1111111;
      end else begin
         shreg_q <= shreg_d;
         cap_q   <= cap_d;
         last_q  <= last_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         upd_q   <= upd_d;
         for (int i = 0; i < 8; i++) hex_q[i] <= hex_d[i];
      end
   end

   always_comb begin
      busy = (state_q != IDLE);
   end

   assign bus.busy = busy;
   assign bus.upd  = upd_q;
   assign bus.ovf  = ovf_q;
   assign bus.hex0 = hex_q[0];
   assign bus.hex1 = hex_q[1];
   assign bus.hex2 = hex_q[2];
   assign bus.hex3 = hex_q[3];
   assign bus.hex4 = hex_q[4];
   assign bus.hex5 = hex_q[5];
   assign bus.hex6 = hex_q[6];
   assign bus.hex7 = hex_q[7];

endmodule

// File: tb/tb_gpio_bcd_display.sv
// Randomized bench for gpio_bcd_display against a decimal-arithmetic display model.
module tb_gpio_bcd_display;

   logic clk = 1'b0;
   logic rst = 1'b1;

   gpio_bcd_display_if bus ();

   gpio_bcd_display dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int upd_cnt = 0;
   int exp_upd = 0;
   longint unsigned prev_v = 0;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
   logic [6:0] exp_hex [8];
   logic       exp_ovf;

   always @(negedge clk) if (bus.upd === 1'b1) upd_cnt++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Display model: decimal digits by division, blanking when the value is below 10^i.
   task automatic model(input longint unsigned v);
      longint unsigned p = 1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0 && v < p) exp_hex[i] = 7'b1111111;
         else                exp_hex[i] = seg_tab[(v / p) % 10];
         p = p * 10;
      end
      exp_ovf = (v > 64'd99_999_999);
   endtask

   function automatic logic [6:0] dut_hex(input int i);
      case (i)
         0: return bus.hex0;
         1: return bus.hex1;
         2: return bus.hex2;
         3: return bus.hex3;
         4: return bus.hex4;
         5: return bus.hex5;
         6: return bus.hex6;
         default: return bus.hex7;
      endcase
   endfunction

   task automatic check_outputs(input longint unsigned v, input string tag);
      model(v);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_hex%0d", tag, i), {57'd0, dut_hex(i)}, {57'd0, exp_hex[i]});
      check({tag, "_ovf"}, {63'd0, bus.ovf}, {63'd0, exp_ovf});
   endtask

   // One conversion; optionally drives din, optionally changes din to mid_v after mid_t edges.
   task automatic convert(input longint unsigned v, input bit set_din,
                          input longint unsigned mid_v, input int mid_t);
      int n;
      if (set_din) bus.din = v[31:0];
      tick();
      n = 1;
      check("busy_start", {63'd0, bus.busy}, 64'd1);
      check("upd_low_start", {63'd0, bus.upd}, 64'd0);
      while (bus.upd !== 1'b1 && n < 80) begin
         if (n == 17) check_outputs(prev_v, "hold");
         if (mid_t > 0 && n == mid_t) bus.din = mid_v[31:0];
         tick();
         n++;
      end
      check("upd_seen", {63'd0, bus.upd}, 64'd1);
      check("latency", 64'(n), 64'd34);
      check("busy_done", {63'd0, bus.busy}, 64'd0);
      check_outputs(v, "result");
      exp_upd++;
      prev_v = v;
      $display("conversion din=%0d latency=%0d hex7..0=%h %h %h %h %h %h %h %h ovf=%0b",
               v, n, bus.hex7, bus.hex6, bus.hex5, bus.hex4,
               bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.ovf);
   endtask

   task automatic idle_check(input int cycles, input string tag);
      repeat (cycles) tick();
      check({tag, "_upd_count"}, 64'(upd_cnt), 64'(exp_upd));
      check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
      $display("idle %s: %0d cycles, upd pulses so far %0d", tag, cycles, upd_cnt);
   endtask

   initial begin
      longint unsigned v;
      longint unsigned v2;
      longint unsigned p;
      int mode;

      bus.din = 32'd0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      idle_check(50, "after_reset");
      check_outputs(0, "reset");

      convert(64'd1234, 1'b1, 0, 0);
      convert(64'hFFFF_FFFF, 1'b1, 0, 0);
      convert(64'd99_999_999, 1'b1, 0, 0);
      convert(64'd100_000_000, 1'b1, 0, 0);
      idle_check(40, "same_value");

      // New value arriving mid-conversion is picked up right after the first result.
      convert(64'd5, 1'b1, 64'd7, 10);
      convert(64'd7, 1'b0, 0, 0);
      idle_check(40, "after_mid_change");

      // Reset aborts a conversion part-way through.
      bus.din = 32'd42;
      repeat (15) tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_outputs(0, "abort");
      check("abort_busy", {63'd0, bus.busy}, 64'd0);
      check("abort_upd_count", 64'(upd_cnt), 64'(exp_upd));
      $display("reset abort: din=42 conversion cancelled");
      prev_v = 0;
      convert(64'd42, 1'b0, 0, 0);

      for (int it = 0; it < 16; it++) begin
         mode = $urandom_range(0, 4);
         case (mode)
            0: v = 64'($urandom);
            1: v = 64'($urandom_range(0, 999));
            2: begin
               p = 1;
               repeat ($urandom_range(1, 9)) p = p * 10;
               v = p - 1 + 64'($urandom_range(0, 2));
            end
            default: v = 64'($urandom);
         endcase
         if (mode == 4) begin
            bus.din = prev_v[31:0];
            idle_check(40, "rand_same");
         end else begin
            if (v == prev_v) v = v ^ 64'd1;
            if (mode == 3) begin
               v2 = v ^ 64'($urandom_range(1, 32'hFFFF));
               convert(v, 1'b1, v2, $urandom_range(1, 33));
               convert(v2, 1'b0, 0, 0);
            end else begin
               convert(v, 1'b1, 0, 0);
            end
         end
      end
      idle_check(40, "final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
